alu4_ctrl: RTL and testbench
============================

# alu4_ctrl

- Command-driven sequencer for a 4-bit combinational ALU with c/n/z/v flags (op encoding 0..7: NOT B, NOT B, AND, OR, XOR, XNOR, ADD, SUB).
- Accepts one command at a time over a valid/ready channel and selects operands from a 4-entry × 4-bit register file or an immediate.
- Drives the ALU ports from registers, captures result and flags, writes the destination register, and returns a response over a second valid/ready channel.
- Sits between a test/host stimulus source and an `alu4` instance.

## Interface

Parameters: none (widths fixed at 4-bit data, 4 registers).

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  controller can accept a command
- `cmd_load`  in  1  1 = load `cmd_imm` into `cmd_rd`, no ALU operation
- `cmd_op`  in  3  ALU opcode
- `cmd_rd`  in  2  destination register
- `cmd_rs`  in  2  source register for ALU input a
- `cmd_rt`  in  2  source register for ALU input b
- `cmd_imm_en`  in  1  1 = ALU input b is `cmd_imm` instead of R[`cmd_rt`]
- `cmd_imm`  in  4  immediate value
- `alu_a`, `alu_b`  out  4  registered ALU operands
- `alu_op`  out  3  registered ALU opcode
- `alu_result`  in  4  ALU result (combinational from `alu_*`)
- `alu_c`, `alu_n`, `alu_z`, `alu_v`  in  1 each  ALU flags
- `rsp_valid`  out  1  response present
- `rsp_ready`  in  1  consumer accepts response
- `rsp_result`  out  4  value written to the destination register
- `rsp_flags`  out  4  flag register {c,n,z,v} after the command

## Operation

FSM states: IDLE, EXEC, RESP.

IDLE
- `cmd_ready`=1.
- On `cmd_valid`&`cmd_ready`, latch the command and go to EXEC.
- For ALU commands, also register: `alu_a`=R[rs]; `alu_b`=imm_en ? imm : R[rt]; `alu_op`=op.
- For load commands, `alu_*` hold their previous values.

EXEC (exactly one cycle)
- ALU command: R[rd]←`alu_result`; flag register←{`alu_c`,`alu_n`,`alu_z`,`alu_v`}; `rsp_result`←`alu_result`.
- Load command: R[rd]←imm; `rsp_result`←imm; flag register unchanged.
- Go to RESP.

RESP
- `rsp_valid`=1; `rsp_result` and `rsp_flags` hold stable.
- On `rsp_valid`&`rsp_ready`, go to IDLE.

Rules:
- `cmd_ready`=1 only in IDLE and only while `reset`=0. `cmd_*` inputs are ignored outside IDLE.
- Only one command is in flight, so read-after-write on the same register always sees the new value.
- rd = rs = rt is legal: operands are sampled before the write.
- The flags are whatever the ALU reports. The controller does not reinterpret them, and they are held until the next ALU command.
- 4-bit wrap-around is the ALU's behaviour; the controller does not extend width.
- Reset (any state, including mid-EXEC or RESP):
  - Next state IDLE; the in-flight command is dropped and no response is issued.
  - R0–R3=0, flags=0, `alu_a`=`alu_b`=0, `alu_op`=0, `rsp_result`=0, `rsp_flags`=0, `rsp_valid`=0.

## Timing

- Command accepted at edge k → `alu_*` valid in cycle k+1.
- Capture and register write at edge k+1.
- `rsp_valid` high from cycle k+2.
- Response accepted at edge m → `cmd_ready` high in cycle m+1.
- Minimum 3 cycles per command with no backpressure.
- `rsp_ready` may be high before `rsp_valid`; a ready consumer completes the response in its first RESP cycle.
- `rsp_ready` low holds RESP indefinitely, with outputs stable.
- All outputs are registered except `cmd_ready`, which is decoded from state and `reset`.

## Test plan

- **Reset:** assert `reset` 2 cycles → all outputs 0, `cmd_ready`=0 during reset and 1 in the first cycle after.
- **Load and add:**
  - load R1=7 and R2=3 → each `rsp_result` = the loaded value, `rsp_flags`=0000.
  - ADD rd=R0, rs=R1, rt=R2 → `rsp_result`=1010, {c,n,z,v}=0101, `rsp_valid` exactly 2 cycles after acceptance.
- **Subtract:** SUB R3=R2−R2 → `rsp_result`=0000, flags {c,n,z,v}=1010. Then a subsequent load → `rsp_flags` still 1010.
- **Immediate:** AND rd=R1, rs=R1, imm_en=1, imm=0101 with R1=0111 → `rsp_result`=0101, and a later read of R1 through an OR with imm=0000 returns 0101.
- **Backpressure:**
  - Hold `rsp_ready`=0 for 5 cycles → `rsp_valid` stays 1 with `rsp_result`/`rsp_flags` unchanged, and `cmd_ready`=0 throughout.
  - A new `cmd_valid` pulse in that window is ignored.
- **Reset mid-operation:** assert `reset` in the EXEC cycle of ADD R0=R1+R2 → no response, R0 reads 0 afterward, and the next command completes normally.

Source files
------------

// File: rtl/alu4_ctrl.sv
// Command sequencer for a 4-bit ALU: register file, operand staging, result/flag capture
// and a valid/ready response channel. Three-state flow IDLE -> EXEC -> RESP.
`timescale 1ns/1ps

module alu4_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_load,
    input  logic [2:0] cmd_op,
    input  logic [1:0] cmd_rd,
    input  logic [1:0] cmd_rs,
    input  logic [1:0] cmd_rt,
    input  logic       cmd_imm_en,
    input  logic [3:0] cmd_imm,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_op,
    input  logic [3:0] alu_result,
    input  logic       alu_c,
    input  logic       alu_n,
    input  logic       alu_z,
    input  logic       alu_v,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [3:0] rsp_result,
    output logic [3:0] rsp_flags
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t     state_r;
    logic [3:0] regs_r [4];
    logic [3:0] flags_r;
    logic       load_r;
    logic [1:0] rd_r;
    logic [3:0] imm_r;
    logic [3:0] alu_a_r;
    logic [3:0] alu_b_r;
    logic [2:0] alu_op_r;
    logic       rsp_valid_r;
    logic [3:0] rsp_result_r;

    // Ready is the only combinational output; it drops immediately while reset is held.
    assign cmd_ready  = (state_r == IDLE) && !reset;

    assign alu_a      = alu_a_r;
    assign alu_b      = alu_b_r;
    assign alu_op     = alu_op_r;
    assign rsp_valid  = rsp_valid_r;
    assign rsp_result = rsp_result_r;
    assign rsp_flags  = flags_r;

    // Sequencer: command capture, operand staging, write-back and response handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            for (int i = 0; i < 4; i++) begin
                regs_r[i] <= 4'd0;
            end
            flags_r      <= 4'd0;
            load_r       <= 1'b0;
            rd_r         <= 2'd0;
            imm_r        <= 4'd0;
            alu_a_r      <= 4'd0;
            alu_b_r      <= 4'd0;
            alu_op_r     <= 3'd0;
            rsp_valid_r  <= 1'b0;
            rsp_result_r <= 4'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (cmd_valid) begin
                        load_r <= cmd_load;
                        rd_r   <= cmd_rd;
                        imm_r  <= cmd_imm;
                        // Operands are sampled here, before any write-back, so rd may alias rs/rt.
                        if (!cmd_load) begin
                            alu_a_r  <= regs_r[cmd_rs];
                            alu_b_r  <= cmd_imm_en ? cmd_imm : regs_r[cmd_rt];
                            alu_op_r <= cmd_op;
                        end else begin
                            alu_a_r  <= alu_a_r;
                            alu_b_r  <= alu_b_r;
                            alu_op_r <= alu_op_r;
                        end
                        state_r <= EXEC;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                EXEC: begin
                    if (load_r) begin
                        regs_r[rd_r] <= imm_r;
                        rsp_result_r <= imm_r;
                    end else begin
                        regs_r[rd_r] <= alu_result;
                        flags_r      <= {alu_c, alu_n, alu_z, alu_v};
                        rsp_result_r <= alu_result;
                    end
                    rsp_valid_r <= 1'b1;
                    state_r     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        state_r     <= IDLE;
                    end else begin
                        state_r     <= RESP;
                    end
                end
                default: begin
                    rsp_valid_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu4_ctrl.sv
// Bench for alu4_ctrl: behavioural ALU stand-in plus a register-file reference model;
// directed scenarios followed by randomized commands.
`timescale 1ns/1ps

module tb_alu4_ctrl;

    logic       clk;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_load;
    logic [2:0] cmd_op;
    logic [1:0] cmd_rd;
    logic [1:0] cmd_rs;
    logic [1:0] cmd_rt;
    logic       cmd_imm_en;
    logic [3:0] cmd_imm;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_op;
    logic [3:0] alu_result;
    logic       alu_c, alu_n, alu_z, alu_v;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_result;
    logic [3:0] rsp_flags;
    logic [7:0] alu_bus;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [3:0] m_regs [4];
    logic [3:0] m_flags;

    alu4_ctrl dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_load(cmd_load),
        .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt),
        .cmd_imm_en(cmd_imm_en), .cmd_imm(cmd_imm),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_c(alu_c), .alu_n(alu_n), .alu_z(alu_z), .alu_v(alu_v),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ALU behaviour from plain integer arithmetic; returns {c,n,z,v,result}.
    function automatic logic [7:0] alu_ref(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        int ia, ib, sa, sb, s;
        logic [3:0] r;
        logic c, v;
        ia = int'(a);
        ib = int'(b);
        sa = (ia > 7) ? ia - 16 : ia;
        sb = (ib > 7) ? ib - 16 : ib;
        c = 1'b0;
        v = 1'b0;
        s = 0;
        case (op)
            3'd0, 3'd1: r = ~b;
            3'd2:       r = a & b;
            3'd3:       r = a | b;
            3'd4:       r = a ^ b;
            3'd5:       r = ~(a ^ b);
            3'd6: begin
                s = ia + ib;
                r = s[3:0];
                c = (s > 15);
                v = ((sa + sb) > 7) || ((sa + sb) < -8);
            end
            3'd7: begin
                s = ia - ib;
                r = s[3:0];
                c = (ia >= ib);
                v = ((sa - sb) > 7) || ((sa - sb) < -8);
            end
            default: r = 4'd0;
        endcase
        return {c, r[3], (r == 4'd0), v, r};
    endfunction

    assign alu_bus    = alu_ref(alu_op, alu_a, alu_b);
    assign alu_result = alu_bus[3:0];
    assign {alu_c, alu_n, alu_z, alu_v} = alu_bus[7:4];

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_regs[i] = 4'd0;
        m_flags = 4'd0;
    endtask

    task automatic model_exec(input logic ld, input logic [2:0] op, input logic [1:0] rd,
                              input logic [1:0] rs, input logic [1:0] rt, input logic ie,
                              input logic [3:0] imm, output logic [3:0] er, output logic [3:0] ef);
        logic [7:0] t;
        if (ld) begin
            m_regs[rd] = imm;
            er = imm;
        end else begin
            t = alu_ref(op, m_regs[rs], ie ? imm : m_regs[rt]);
            m_regs[rd] = t[3:0];
            m_flags = t[7:4];
            er = t[3:0];
        end
        ef = m_flags;
    endtask

    // Waits (bounded) for cmd_ready, presents one command for one edge; returns staged ALU regs.
    task automatic send_cmd(input logic ld, input logic [2:0] op, input logic [1:0] rd,
                            input logic [1:0] rs, input logic [1:0] rt, input logic ie,
                            input logic [3:0] imm, output logic ok, output int acc,
                            output logic [3:0] oa, output logic [3:0] ob, output logic [2:0] oop);
        ok = 1'b0;
        acc = 0;
        for (int n = 0; n < 20 && !cmd_ready; n++) begin
            @(posedge clk); #1;
        end
        if (cmd_ready) begin
            cmd_valid = 1'b1; cmd_load = ld; cmd_op = op; cmd_rd = rd;
            cmd_rs = rs; cmd_rt = rt; cmd_imm_en = ie; cmd_imm = imm;
            @(posedge clk); #1;
            acc = cyc;
            ok = 1'b1;
        end
        cmd_valid = 1'b0;
        cmd_load = 1'($urandom); cmd_op = 3'($urandom); cmd_rd = 2'($urandom);
        cmd_rs = 2'($urandom); cmd_rt = 2'($urandom); cmd_imm_en = 1'($urandom);
        cmd_imm = 4'($urandom);
        oa = alu_a; ob = alu_b; oop = alu_op;
    endtask

    task automatic wait_rsp(output int lat, output logic ok);
        lat = 0;
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (rsp_valid) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic take_rsp(output logic [3:0] res, output logic [3:0] flg);
        res = rsp_result;
        flg = rsp_flags;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_load = 1'b0; cmd_op = 3'd0; cmd_rd = 2'd0; cmd_rs = 2'd0; cmd_rt = 2'd0;
        cmd_imm_en = 1'b0; cmd_imm = 4'd0;
        @(posedge clk); #1;
        n_cmp++;
        if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready_1: got %b want 0", cmd_ready); end
        @(posedge clk); #1;
        n_cmp++;
        if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready_2: got %b want 0", cmd_ready); end
        n_cmp++;
        if ({alu_a, alu_b, alu_op, rsp_valid, rsp_result, rsp_flags} !== 20'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got a=%b b=%b op=%b v=%b r=%b f=%b want all 0",
                     alu_a, alu_b, alu_op, rsp_valid, rsp_result, rsp_flags);
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_ready: got %b want 1", cmd_ready); end
        model_reset();
    endtask

    task automatic test_load_add();
        logic ok; int acc, lat; logic [3:0] oa, ob, res, flg, er, ef; logic [2:0] oop;
        send_cmd(1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 1'b0, 4'd7, ok, acc, oa, ob, oop);
        model_exec(1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 1'b0, 4'd7, er, ef);
        wait_rsp(lat, ok);
        take_rsp(res, flg);
        n_cmp++;
        if (res !== 4'd7 || flg !== 4'b0000) begin n_err++; $display("FAIL load_r1: got r=%b f=%b want 0111/0000", res, flg); end
        n_cmp++;
        if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL ready_after_rsp: got %b want 1", cmd_ready); end
        send_cmd(1'b1, 3'd0, 2'd2, 2'd0, 2'd0, 1'b0, 4'd3, ok, acc, oa, ob, oop);
        model_exec(1'b1, 3'd0, 2'd2, 2'd0, 2'd0, 1'b0, 4'd3, er, ef);
        n_cmp++;
        if ({oa, ob, oop} !== 11'd0) begin n_err++; $display("FAIL load_holds_alu: got a=%b b=%b op=%b want 0", oa, ob, oop); end
        wait_rsp(lat, ok);
        take_rsp(res, flg);
        n_cmp++;
        if (res !== 4'd3 || flg !== 4'b0000) begin n_err++; $display("FAIL load_r2: got r=%b f=%b want 0011/0000", res, flg); end
        send_cmd(1'b0, 3'd6, 2'd0, 2'd1, 2'd2, 1'b0, 4'd9, ok, acc, oa, ob, oop);
        model_exec(1'b0, 3'd6, 2'd0, 2'd1, 2'd2, 1'b0, 4'd9, er, ef);
        n_cmp++;
        if (oa !== 4'd7 || ob !== 4'd3 || oop !== 3'd6) begin n_err++; $display("FAIL add_operands: got a=%b b=%b op=%b want 0111/0011/110", oa, ob, oop); end
        wait_rsp(lat, ok);
        n_cmp++;
        if (!ok || lat != 1) begin n_err++; $display("FAIL add_latency: got lat=%0d ok=%b want 1", lat, ok); end
        take_rsp(res, flg);
        n_cmp++;
        if (res !== 4'b1010 || flg !== 4'b0101) begin n_err++; $display("FAIL add_result: got r=%b f=%b want 1010/0101", res, flg); end
    endtask

    task automatic test_sub();
        logic ok; int acc, lat; logic [3:0] oa, ob, res, flg, er, ef; logic [2:0] oop;
        send_cmd(1'b0, 3'd7, 2'd3, 2'd2, 2'd2, 1'b0, 4'd1, ok, acc, oa, ob, oop);
        model_exec(1'b0, 3'd7, 2'd3, 2'd2, 2'd2, 1'b0, 4'd1, er, ef);
        wait_rsp(lat, ok);
        take_rsp(res, flg);
        n_cmp++;
        if (res !== 4'b0000 || flg !== 4'b1010) begin n_err++; $display("FAIL sub_result: got r=%b f=%b want 0000/1010", res, flg); end
        send_cmd(1'b1, 3'd0, 2'd0, 2'd0, 2'd0, 1'b0, 4'd9, ok, acc, oa, ob, oop);
        model_exec(1'b1, 3'd0, 2'd0, 2'd0, 2'd0, 1'b0, 4'd9, er, ef);
        wait_rsp(lat, ok);
        take_rsp(res, flg);
        n_cmp++;
        if (res !== 4'd9 || flg !== 4'b1010) begin n_err++; $display("FAIL load_keeps_flags: got r=%b f=%b want 1001/1010", res, flg); end
    endtask

    task automatic test_imm();
        logic ok; int acc, lat; logic [3:0] oa, ob, res, flg, er, ef; logic [2:0] oop;
        send_cmd(1'b0, 3'd2, 2'd1, 2'd1, 2'd3, 1'b1, 4'b0101, ok, acc, oa, ob, oop);
        model_exec(1'b0, 3'd2, 2'd1, 2'd1, 2'd3, 1'b1, 4'b0101, er, ef);
        wait_rsp(lat, ok);
        take_rsp(res, flg);
        n_cmp++;
        if (res !== 4'b0101 || flg !== ef) begin n_err++; $display("FAIL and_imm: got r=%b f=%b want 0101/%b", res, flg, ef); end
        send_cmd(1'b0, 3'd3, 2'd2, 2'd1, 2'd0, 1'b1, 4'b0000, ok, acc, oa, ob, oop);
        model_exec(1'b0, 3'd3, 2'd2, 2'd1, 2'd0, 1'b1, 4'b0000, er, ef);
        wait_rsp(lat, ok);
        take_rsp(res, flg);
        n_cmp++;
        if (res !== 4'b0101 || flg !== ef) begin n_err++; $display("FAIL or_readback: got r=%b f=%b want 0101/%b", res, flg, ef); end
    endtask

    task automatic test_backpressure();
        logic ok; int acc, lat; logic [3:0] oa, ob, res, flg, er, ef; logic [2:0] oop;
        send_cmd(1'b0, 3'd6, 2'd3, 2'd1, 2'd2, 1'b0, 4'd0, ok, acc, oa, ob, oop);
        model_exec(1'b0, 3'd6, 2'd3, 2'd1, 2'd2, 1'b0, 4'd0, er, ef);
        wait_rsp(lat, ok);
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (rsp_valid !== 1'b1 || rsp_result !== er || rsp_flags !== ef || cmd_ready !== 1'b0) begin
                n_err++;
                $display("FAIL stall_cycle_%0d: got v=%b r=%b f=%b rdy=%b want 1/%b/%b/0",
                         i, rsp_valid, rsp_result, rsp_flags, cmd_ready, er, ef);
            end
            cmd_valid = (i == 1); cmd_load = 1'b1; cmd_rd = 2'd3; cmd_imm = 4'hF;
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        take_rsp(res, flg);
        n_cmp++;
        if (res !== er || flg !== ef) begin n_err++; $display("FAIL stall_release: got r=%b f=%b want %b/%b", res, flg, er, ef); end
        send_cmd(1'b0, 3'd3, 2'd0, 2'd3, 2'd0, 1'b1, 4'd0, ok, acc, oa, ob, oop);
        model_exec(1'b0, 3'd3, 2'd0, 2'd3, 2'd0, 1'b1, 4'd0, er, ef);
        wait_rsp(lat, ok);
        take_rsp(res, flg);
        n_cmp++;
        if (res !== er) begin n_err++; $display("FAIL stall_cmd_ignored: got R3=%b want %b", res, er); end
    endtask

    task automatic test_reset_mid();
        logic ok; int acc, lat; logic [3:0] oa, ob, res, flg, er, ef; logic [2:0] oop;
        send_cmd(1'b0, 3'd6, 2'd0, 2'd1, 2'd2, 1'b0, 4'd0, ok, acc, oa, ob, oop);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL mid_reset_no_rsp_%0d: got %b want 0", i, rsp_valid); end
            @(posedge clk); #1;
        end
        send_cmd(1'b0, 3'd3, 2'd1, 2'd0, 2'd0, 1'b1, 4'd0, ok, acc, oa, ob, oop);
        model_exec(1'b0, 3'd3, 2'd1, 2'd0, 2'd0, 1'b1, 4'd0, er, ef);
        wait_rsp(lat, ok);
        n_cmp++;
        if (!ok || lat != 1) begin n_err++; $display("FAIL after_reset_latency: got lat=%0d ok=%b want 1", lat, ok); end
        take_rsp(res, flg);
        n_cmp++;
        if (res !== 4'd0 || flg !== 4'b0010) begin n_err++; $display("FAIL r0_after_reset: got r=%b f=%b want 0000/0010", res, flg); end
    endtask

    task automatic test_back_to_back();
        logic ok; int acc, prev, lat; logic [3:0] oa, ob, er, ef; logic [2:0] oop;
        logic ld, ie; logic [2:0] op; logic [1:0] rd, rs, rt; logic [3:0] imm;
        rsp_ready = 1'b1;
        prev = 0;
        for (int i = 0; i < 5; i++) begin
            ld = 1'($urandom); op = 3'($urandom); rd = 2'($urandom); rs = 2'($urandom);
            rt = 2'($urandom); ie = 1'($urandom); imm = 4'($urandom);
            send_cmd(ld, op, rd, rs, rt, ie, imm, ok, acc, oa, ob, oop);
            model_exec(ld, op, rd, rs, rt, ie, imm, er, ef);
            if (i > 0) begin
                n_cmp++;
                if (acc - prev != 3) begin n_err++; $display("FAIL b2b_spacing_%0d: got %0d want 3", i, acc - prev); end
            end
            prev = acc;
            wait_rsp(lat, ok);
            n_cmp++;
            if (!ok || rsp_result !== er || rsp_flags !== ef) begin
                n_err++;
                $display("FAIL b2b_rsp_%0d: got r=%b f=%b want %b/%b", i, rsp_result, rsp_flags, er, ef);
            end
        end
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_random();
        logic ok; int acc, lat, stall; logic [3:0] oa, ob, res, flg, er, ef; logic [2:0] oop;
        logic ld, ie; logic [2:0] op; logic [1:0] rd, rs, rt; logic [3:0] imm;
        for (int i = 0; i < 40; i++) begin
            ld = ($urandom_range(3, 0) == 0); op = 3'($urandom); rd = 2'($urandom);
            rs = 2'($urandom); rt = 2'($urandom); ie = 1'($urandom); imm = 4'($urandom);
            stall = $urandom_range(3, 0);
            rsp_ready = (stall == 0) ? 1'($urandom) : 1'b0;
            send_cmd(ld, op, rd, rs, rt, ie, imm, ok, acc, oa, ob, oop);
            model_exec(ld, op, rd, rs, rt, ie, imm, er, ef);
            wait_rsp(lat, ok);
            n_cmp++;
            if (!ok || lat != 1) begin n_err++; $display("FAIL rnd_latency_%0d: got lat=%0d ok=%b want 1", i, lat, ok); end
            for (int s = 0; s < stall; s++) begin
                @(posedge clk); #1;
            end
            take_rsp(res, flg);
            n_cmp++;
            if (res !== er || flg !== ef) begin
                n_err++;
                $display("FAIL rnd_rsp_%0d: got r=%b f=%b want %b/%b (ld=%b op=%0d rd=%0d rs=%0d rt=%0d ie=%b imm=%b)",
                         i, res, flg, er, ef, ld, op, rd, rs, rt, ie, imm);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_add();
        test_sub();
        test_imm();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
